// File: rtl/fetch_queue_decode_if.sv
// Fetch-to-decode bundle: fetch-side push, hazard controls, and the decode-stage view.
// Signal names keep the pipeline's F/D stage naming so the core's wiring reads unchanged.
interface fetch_queue_decode_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
);
    logic                  push_i;
    logic [DATA_WIDTH-1:0] InstrF_i;
    logic [DATA_WIDTH-1:0] PCF_i;
    logic [DATA_WIDTH-1:0] PCPlus4F_i;
    logic                  stallD_i;
    logic                  flush_i;
    logic                  full_o;
    logic [CNT_WIDTH-1:0]  count_o;
    logic [DATA_WIDTH-1:0] InstrD_o;
    logic [DATA_WIDTH-1:0] PCD_o;
    logic [DATA_WIDTH-1:0] PCPlus4D_o;
    logic                  validD_o;
    logic [DATA_WIDTH-1:0] ImmOpD_o;

    modport master (
        output push_i, InstrF_i, PCF_i, PCPlus4F_i, stallD_i, flush_i,
        input  full_o, count_o, InstrD_o, PCD_o, PCPlus4D_o, validD_o, ImmOpD_o
    );

    modport slave (
        input  push_i, InstrF_i, PCF_i, PCPlus4F_i, stallD_i, flush_i,
        output full_o, count_o, InstrD_o, PCD_o, PCPlus4D_o, validD_o, ImmOpD_o
    );
endinterface

// File: rtl/fetch_queue_decode.sv
// Circular instruction queue between fetch and decode, with a decode register that tracks
// valid/bubble, a redirect flush, and the decode-stage immediate (registered with InstrD).
module fetch_queue_decode #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input logic                 clk,
    input logic                 rst_ni,
    fetch_queue_decode_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);

    // Immediate extraction for the RV32 base formats; unknown opcodes yield zero.
    function automatic logic [31:0] imm_ext(input logic [31:0] instr);
        logic [31:0] imm;
        case (instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111:
                imm = {{20{instr[31]}}, instr[31:20]};
            7'b0100011:
                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            7'b1100011:
                imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm = {instr[31:12], 12'b0};
            7'b1101111:
                imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm = 32'h0000_0000;
        endcase
        return imm;
    endfunction

    logic [DATA_WIDTH-1:0] instr_mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] pc_mem_r    [DEPTH];
    logic [DATA_WIDTH-1:0] pcp4_mem_r  [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r, wr_ptr_next_s, rd_ptr_next_s;
    logic [CNT_WIDTH-1:0]  count_r, count_next_s;
    logic                  full_r, full_next_s;
    logic                  push_ok_s, pop_s;
    logic [DATA_WIDTH-1:0] instr_d_r, pc_d_r, pcp4_d_r, imm_d_r;
    logic [DATA_WIDTH-1:0] instr_d_next_s, pc_d_next_s, pcp4_d_next_s, imm_d_next_s;
    logic                  valid_d_r, valid_d_next_s;
    logic [31:0]           imm32_s;

    // Accept/pop qualification; a redirect cancels both for the cycle.
    always_comb begin
        push_ok_s = bus.push_i && !full_r && !bus.flush_i;
        pop_s     = !bus.stallD_i && (count_r != {CNT_WIDTH{1'b0}}) && !bus.flush_i;
    end

    // Next-state for pointers, occupancy and the decode register.
    always_comb begin
        wr_ptr_next_s  = wr_ptr_r;
        rd_ptr_next_s  = rd_ptr_r;
        count_next_s   = count_r;
        instr_d_next_s = instr_d_r;
        pc_d_next_s    = pc_d_r;
        pcp4_d_next_s  = pcp4_d_r;
        valid_d_next_s = valid_d_r;
        if (bus.flush_i) begin
            wr_ptr_next_s  = {PTR_W{1'b0}};
            rd_ptr_next_s  = {PTR_W{1'b0}};
            count_next_s   = {CNT_WIDTH{1'b0}};
            instr_d_next_s = NOP_INSTR;
            valid_d_next_s = 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_next_s = wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_next_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_next_s = rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_next_s = rd_ptr_r;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_next_s = count_r + CNT_WIDTH'(1);
                2'b01:   count_next_s = count_r - CNT_WIDTH'(1);
                default: count_next_s = count_r;
            endcase
            // PCs hold across a bubble so decode always sees the last real PC.
            if (bus.stallD_i) begin
                valid_d_next_s = valid_d_r;
            end else if (pop_s) begin
                instr_d_next_s = instr_mem_r[rd_ptr_r];
                pc_d_next_s    = pc_mem_r[rd_ptr_r];
                pcp4_d_next_s  = pcp4_mem_r[rd_ptr_r];
                valid_d_next_s = 1'b1;
            end else begin
                instr_d_next_s = NOP_INSTR;
                valid_d_next_s = 1'b0;
            end
        end
        full_next_s  = (count_next_s == CNT_WIDTH'(DEPTH));
        imm32_s      = imm_ext(instr_d_next_s[31:0]);
        imm_d_next_s = {{(DATA_WIDTH-31){imm32_s[31]}}, imm32_s[30:0]};
    end

    // Queue storage; contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            instr_mem_r[wr_ptr_r] <= bus.InstrF_i;
            pc_mem_r[wr_ptr_r]    <= bus.PCF_i;
            pcp4_mem_r[wr_ptr_r]  <= bus.PCPlus4F_i;
        end
    end

    // Control state and decode register.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_r  <= {PTR_W{1'b0}};
            rd_ptr_r  <= {PTR_W{1'b0}};
            count_r   <= {CNT_WIDTH{1'b0}};
            full_r    <= 1'b0;
            instr_d_r <= NOP_INSTR;
            pc_d_r    <= {DATA_WIDTH{1'b0}};
            pcp4_d_r  <= {DATA_WIDTH{1'b0}};
            imm_d_r   <= {DATA_WIDTH{1'b0}};
            valid_d_r <= 1'b0;
        end else begin
            wr_ptr_r  <= wr_ptr_next_s;
            rd_ptr_r  <= rd_ptr_next_s;
            count_r   <= count_next_s;
            full_r    <= full_next_s;
            instr_d_r <= instr_d_next_s;
            pc_d_r    <= pc_d_next_s;
            pcp4_d_r  <= pcp4_d_next_s;
            imm_d_r   <= imm_d_next_s;
            valid_d_r <= valid_d_next_s;
        end
    end

    assign bus.full_o     = full_r;
    assign bus.count_o    = count_r;
    assign bus.InstrD_o   = instr_d_r;
    assign bus.PCD_o      = pc_d_r;
    assign bus.PCPlus4D_o = pcp4_d_r;
    assign bus.validD_o   = valid_d_r;
    assign bus.ImmOpD_o   = imm_d_r;
endmodule

// File: tb/tb_fetch_queue_decode.sv
// Directed bench for fetch_queue_decode: stimulus pushes expected decode entries into a
// scoreboard, a negedge monitor pops and compares each new valid D-stage instruction.
module tb_fetch_queue_decode;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    fetch_queue_decode_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) bus ();

    fetch_queue_decode #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk    (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcp4;
        logic [31:0] imm;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock of stimulus; returns one ns after the following falling edge.
    task automatic cycle(input logic push, input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] imm, input logic stall, input logic flush,
                         input logic accept);
        bus.push_i     = push;
        bus.InstrF_i   = instr;
        bus.PCF_i      = pc;
        bus.PCPlus4F_i = pc + 32'd4;
        bus.stallD_i   = stall;
        bus.flush_i    = flush;
        if (flush) sb.delete();
        else if (push && accept) sb.push_back('{instr, pc, pc + 32'd4, imm});
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input logic stall);
        cycle(1'b0, 32'h0, 32'h0, 32'h0, stall, 1'b0, 1'b0);
    endtask

    // Monitor: a new D entry is a rising validD or a PC change while valid (PCs are unique).
    initial begin
        logic        prev_valid;
        logic [31:0] prev_pc;
        exp_t        e;
        prev_valid = 1'b0;
        prev_pc    = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                prev_valid = 1'b0;
            end else begin
                if (bus.validD_o && (!prev_valid || bus.PCD_o != prev_pc)) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_d: got pc %h expected no entry", bus.PCD_o);
                    end else begin
                        e = sb.pop_front();
                        check("d_instr", bus.InstrD_o, e.instr);
                        check("d_pc", bus.PCD_o, e.pc);
                        check("d_pcp4", bus.PCPlus4D_o, e.pcp4);
                        check("d_imm", bus.ImmOpD_o, e.imm);
                    end
                end
                prev_valid = bus.validD_o;
                prev_pc    = bus.PCD_o;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.push_i = 1'b0; bus.InstrF_i = 32'h0; bus.PCF_i = 32'h0; bus.PCPlus4F_i = 32'h0;
        bus.stallD_i = 1'b0; bus.flush_i = 1'b0;
        @(negedge clk); #1;
        check("rst_instr", bus.InstrD_o, NOP);
        check("rst_valid", 32'(bus.validD_o), 32'd0);
        check("rst_count", 32'(bus.count_o), 32'd0);
        check("rst_full", 32'(bus.full_o), 32'd0);
        check("rst_pc", bus.PCD_o, 32'h0);
        check("rst_pcp4", bus.PCPlus4D_o, 32'h0);
        check("rst_imm", bus.ImmOpD_o, 32'h0);
        @(negedge clk); #1;
        rst_ni = 1'b1;

        // Streaming: one push per cycle, D follows two edges after the first push.
        cycle(1'b1, 32'hFFF0_0093, 32'h00, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        check("s_count1", 32'(bus.count_o), 32'd1);
        check("s_valid1", 32'(bus.validD_o), 32'd0);
        cycle(1'b1, 32'hFE00_0EE3, 32'h04, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b1);
        check("s_valid2", 32'(bus.validD_o), 32'd1);
        check("s_pc2", bus.PCD_o, 32'h00);
        check("s_count2", 32'(bus.count_o), 32'd1);
        cycle(1'b1, 32'h0000_12B7, 32'h08, 32'h0000_1000, 1'b0, 1'b0, 1'b1);
        check("s_count3", 32'(bus.count_o), 32'd1);
        idle(1'b0);
        check("s_count4", 32'(bus.count_o), 32'd0);
        check("s_pc4", bus.PCD_o, 32'h08);
        idle(1'b0);
        check("bub_valid", 32'(bus.validD_o), 32'd0);
        check("bub_instr", bus.InstrD_o, NOP);
        check("bub_pc_hold", bus.PCD_o, 32'h08);
        check("bub_pcp4_hold", bus.PCPlus4D_o, 32'h0C);
        check("bub_imm", bus.ImmOpD_o, 32'h0);

        // Fill under stall: 4 accepted, fifth refused, then drain in order.
        cycle(1'b1, 32'h0080_006F, 32'h10, 32'h0000_0008, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'hFE00_0E23, 32'h14, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h0080_2103, 32'h18, 32'h0000_0008, 1'b1, 1'b0, 1'b1);
        check("f_full3", 32'(bus.full_o), 32'd0);
        cycle(1'b1, 32'h8000_0067, 32'h1C, 32'hFFFF_F800, 1'b1, 1'b0, 1'b1);
        check("f_full4", 32'(bus.full_o), 32'd1);
        check("f_count4", 32'(bus.count_o), 32'd4);
        cycle(1'b1, 32'hABCD_E017, 32'h20, 32'hABCD_E000, 1'b1, 1'b0, 1'b0);
        check("f_count5", 32'(bus.count_o), 32'd4);
        check("f_stall_valid", 32'(bus.validD_o), 32'd0);
        idle(1'b0);
        check("f_full_pop", 32'(bus.full_o), 32'd0);
        check("f_count_pop", 32'(bus.count_o), 32'd3);
        for (int i = 0; i < 3; i++) idle(1'b0);
        check("f_count_empty", 32'(bus.count_o), 32'd0);
        idle(1'b0);
        check("f_bubble", 32'(bus.validD_o), 32'd0);

        // Flush with D valid, three queued, push and stall asserted.
        cycle(1'b1, 32'h0000_0033, 32'h30, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h0000_0033, 32'h34, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h0000_0033, 32'h38, 32'h0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h0000_0033, 32'h3C, 32'h0, 1'b1, 1'b0, 1'b1);
        check("fl_pre_count", 32'(bus.count_o), 32'd3);
        check("fl_pre_valid", 32'(bus.validD_o), 32'd1);
        cycle(1'b1, 32'h0000_0033, 32'h40, 32'h0, 1'b1, 1'b1, 1'b0);
        check("fl_count", 32'(bus.count_o), 32'd0);
        check("fl_valid", 32'(bus.validD_o), 32'd0);
        check("fl_instr", bus.InstrD_o, NOP);
        cycle(1'b1, 32'hABCD_E017, 32'h44, 32'hABCD_E000, 1'b0, 1'b0, 1'b1);
        check("fl_next_count", 32'(bus.count_o), 32'd1);
        check("fl_next_valid0", 32'(bus.validD_o), 32'd0);
        idle(1'b0);
        check("fl_next_pc", bus.PCD_o, 32'h44);
        idle(1'b0);

        // Wrap: hold occupancy at 2 with simultaneous push/pop.
        cycle(1'b1, 32'h0000_0033, 32'h100, 32'h0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h0000_0033, 32'h104, 32'h0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 1)
                cycle(1'b1, 32'h0080_2103, 32'h108 + 32'(4 * i), 32'h8, 1'b0, 1'b0, 1'b1);
            else
                cycle(1'b1, 32'h0000_0033, 32'h108 + 32'(4 * i), 32'h0, 1'b0, 1'b0, 1'b1);
            check("w_count", 32'(bus.count_o), 32'd2);
        end
        for (int i = 0; i < 3; i++) idle(1'b0);
        check("w_drained", 32'(bus.count_o), 32'd0);

        // Asynchronous reset between edges with three entries queued and D valid.
        cycle(1'b1, 32'h0000_0033, 32'h1F0, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h0000_0033, 32'h200, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h0000_0033, 32'h204, 32'h0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 32'h0000_0033, 32'h208, 32'h0, 1'b1, 1'b0, 1'b1);
        check("r_pre_count", 32'(bus.count_o), 32'd3);
        bus.push_i = 1'b0;
        #2;
        rst_ni = 1'b0;
        sb.delete();
        #1;
        check("r_instr", bus.InstrD_o, NOP);
        check("r_valid", 32'(bus.validD_o), 32'd0);
        check("r_count", 32'(bus.count_o), 32'd0);
        check("r_pc", bus.PCD_o, 32'h0);
        @(negedge clk); #1;
        rst_ni = 1'b1;
        cycle(1'b1, 32'h0080_006F, 32'h300, 32'h8, 1'b0, 1'b0, 1'b1);
        check("r_after_count", 32'(bus.count_o), 32'd1);
        idle(1'b0);
        check("r_after_pc", bus.PCD_o, 32'h300);
        idle(1'b0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
